// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared ROB sizing, opcode constants and entry layout
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // For stores rd_value carries the address and rs1_value the data.
    typedef struct packed {
        logic [6:0]  rd_opcode;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic [31:0] rs1_value;
        logic [31:0] rd_value;
    } rob_entry;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/occupancy bookkeeping and allocation gating
module rob_ptr_ctrl
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDX_W = ROB_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       alloc_cnt,
    input  logic [1:0]       retire_cnt,
    output logic             alloc_ready,
    output logic [1:0]       alloc_acc,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] READY_MAX = (IDX_W + 1)'(DEPTH - 2);

    // Ready ignores same-cycle retires so it never depends on the retire mux.
    assign alloc_ready = (count <= READY_MAX);
    assign alloc_acc   = (alloc_ready && alloc_cnt != 2'd3) ? alloc_cnt : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IDX_W'(retire_cnt);
            tail  <= tail + IDX_W'(alloc_acc);
            count <= count + (IDX_W + 1)'(alloc_acc) - (IDX_W + 1)'(retire_cnt);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - dual-issue circular reorder buffer with in-order dual retire
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDX_W = ROB_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alloc_cnt,
    input  rob_entry         alloc_1,
    input  rob_entry         alloc_2,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx_1,
    output logic [IDX_W-1:0] alloc_idx_2,
    input  logic             cpl_valid_1,
    input  logic [IDX_W-1:0] cpl_idx_1,
    input  logic [31:0]      cpl_value_1,
    input  logic             cpl_valid_2,
    input  logic [IDX_W-1:0] cpl_idx_2,
    input  logic [31:0]      cpl_value_2,
    input  logic             flush,
    output rob_entry         rob_o_1,
    output rob_entry         rob_o_2,
    output logic [1:0]       num_retired,
    output logic [IDX_W:0]   count
);

    rob_entry         entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] complete;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] head_p1;
    logic [1:0]       alloc_acc;
    logic [1:0]       retire_cnt;
    logic             ret_1;
    logic             ret_2;
    logic             cpl_ok_1;
    logic             cpl_ok_2;

    rob_ptr_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_cnt   (alloc_cnt),
        .retire_cnt  (retire_cnt),
        .alloc_ready (alloc_ready),
        .alloc_acc   (alloc_acc),
        .head        (head),
        .tail        (tail),
        .count       (count)
    );

    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = tail + IDX_W'(1);
    assign head_p1     = head + IDX_W'(1);

    // Retire looks only at registered complete bits, adding one cycle after completion.
    assign ret_1      = valid[head] & complete[head];
    assign ret_2      = ret_1 & valid[head_p1] & complete[head_p1];
    assign retire_cnt = ret_2 ? 2'd2 : (ret_1 ? 2'd1 : 2'd0);

    assign cpl_ok_1 = cpl_valid_1 & valid[cpl_idx_1];
    assign cpl_ok_2 = cpl_valid_2 & valid[cpl_idx_2];

    // Port 1 is written last so it wins a same-tag collision.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (alloc_acc != 2'd0) begin
                entries[alloc_idx_1] <= alloc_1;
            end
            if (alloc_acc == 2'd2) begin
                entries[alloc_idx_2] <= alloc_2;
            end
            if (cpl_ok_2) begin
                entries[cpl_idx_2].rd_value <= cpl_value_2;
            end
            if (cpl_ok_1) begin
                entries[cpl_idx_1].rd_value <= cpl_value_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= '0;
            complete <= '0;
        end else if (flush) begin
            valid    <= '0;
            complete <= '0;
        end else begin
            if (ret_1) begin
                valid[head] <= 1'b0;
            end
            if (ret_2) begin
                valid[head_p1] <= 1'b0;
            end
            if (cpl_ok_2) begin
                complete[cpl_idx_2] <= 1'b1;
            end
            if (cpl_ok_1) begin
                complete[cpl_idx_1] <= 1'b1;
            end
            if (alloc_acc != 2'd0) begin
                valid[alloc_idx_1]    <= 1'b1;
                complete[alloc_idx_1] <= 1'b0;
            end
            if (alloc_acc == 2'd2) begin
                valid[alloc_idx_2]    <= 1'b1;
                complete[alloc_idx_2] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rob_o_1     <= '0;
            rob_o_2     <= '0;
            num_retired <= 2'd0;
        end else if (flush) begin
            num_retired <= 2'd0;
        end else begin
            num_retired <= retire_cnt;
            if (ret_1) begin
                rob_o_1 <= entries[head];
            end
            if (ret_2) begin
                rob_o_2 <= entries[head_p1];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  alloc_cnt = 2'd0;
    rob_entry    alloc_1 = '0;
    rob_entry    alloc_2 = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_idx_1;
    logic [3:0]  alloc_idx_2;
    logic        cpl_valid_1 = 1'b0;
    logic [3:0]  cpl_idx_1 = '0;
    logic [31:0] cpl_value_1 = '0;
    logic        cpl_valid_2 = 1'b0;
    logic [3:0]  cpl_idx_2 = '0;
    logic [31:0] cpl_value_2 = '0;
    logic        flush = 1'b0;
    rob_entry    rob_o_1;
    rob_entry    rob_o_2;
    logic [1:0]  num_retired;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_cnt   (alloc_cnt),
        .alloc_1     (alloc_1),
        .alloc_2     (alloc_2),
        .alloc_ready (alloc_ready),
        .alloc_idx_1 (alloc_idx_1),
        .alloc_idx_2 (alloc_idx_2),
        .cpl_valid_1 (cpl_valid_1),
        .cpl_idx_1   (cpl_idx_1),
        .cpl_value_1 (cpl_value_1),
        .cpl_valid_2 (cpl_valid_2),
        .cpl_idx_2   (cpl_idx_2),
        .cpl_value_2 (cpl_value_2),
        .flush       (flush),
        .rob_o_1     (rob_o_1),
        .rob_o_2     (rob_o_2),
        .num_retired (num_retired),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rob_entry mk(input logic [4:0] rd);
        rob_entry e;
        e           = '0;
        e.rd_addr   = rd;
        e.pc        = {25'd0, rd, 2'b00};
        e.rd_value  = 32'hDEAD_BEEF;
        return e;
    endfunction

    task automatic alloc(input logic [1:0] n, input rob_entry a, input rob_entry b);
        alloc_cnt = n;
        alloc_1   = a;
        alloc_2   = b;
        tick();
        alloc_cnt = 2'd0;
    endtask

    task automatic cpl(input logic v1, input logic [3:0] i1, input logic [31:0] x1,
                       input logic v2, input logic [3:0] i2, input logic [31:0] x2);
        cpl_valid_1 = v1; cpl_idx_1 = i1; cpl_value_1 = x1;
        cpl_valid_2 = v2; cpl_idx_2 = i2; cpl_value_2 = x2;
        tick();
        cpl_valid_1 = 1'b0;
        cpl_valid_2 = 1'b0;
    endtask

    initial begin
        rob_entry st;
        logic     stalled;

        // Reset state
        #12;
        check_eq("rst_count", count, 5'd0);
        check_eq("rst_num_retired", num_retired, 2'd0);
        check_eq("rst_alloc_ready", alloc_ready, 1'b1);
        check_eq("rst_alloc_idx_1", alloc_idx_1, 4'd0);
        check_eq("rst_alloc_idx_2", alloc_idx_2, 4'd1);
        check_eq("rst_rob_o_1", rob_o_1, '0);
        rst_n = 1'b1;
        tick();

        // Out-of-order completion, in-order dual retire
        alloc(2'd2, mk(5'd1), mk(5'd2));
        check_eq("t1_count", count, 5'd2);
        check_eq("t1_tail", alloc_idx_1, 4'd2);
        cpl(1'b1, 4'd1, 32'h10, 1'b0, 4'd0, 32'h0);
        check_eq("t1_no_retire_a", num_retired, 2'd0);
        cpl(1'b1, 4'd0, 32'h20, 1'b0, 4'd0, 32'h0);
        check_eq("t1_no_retire_b", num_retired, 2'd0);
        tick();
        check_eq("t1_num_retired", num_retired, 2'd2);
        check_eq("t1_o1_value", rob_o_1.rd_value, 32'h20);
        check_eq("t1_o2_value", rob_o_2.rd_value, 32'h10);
        check_eq("t1_o1_rd", rob_o_1.rd_addr, 5'd1);
        check_eq("t1_count_after", count, 5'd0);
        tick();
        check_eq("t1_idle", num_retired, 2'd0);
        check_eq("t1_hold", rob_o_1.rd_value, 32'h20);

        // Head incomplete blocks retirement
        alloc(2'd2, mk(5'd3), mk(5'd4));
        cpl(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0);
        stalled = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (num_retired != 2'd0) stalled = 1'b0;
        end
        check_eq("t2_stall", stalled, 1'b1);
        check_eq("t2_count", count, 5'd2);
        cpl(1'b1, 4'd2, 32'h32, 1'b0, 4'd0, 32'h0);
        tick();
        check_eq("t2_num_retired", num_retired, 2'd2);
        check_eq("t2_o1_value", rob_o_1.rd_value, 32'h32);
        check_eq("t2_o2_value", rob_o_2.rd_value, 32'h33);
        tick();
        check_eq("t2_count_after", count, 5'd0);

        // Store passes through with address/data roles intact
        check_eq("st_tag", alloc_idx_1, 4'd4);
        st           = mk(5'd5);
        st.rd_opcode = OPC_STORE;
        st.rs1_value = 32'hAB;
        alloc(2'd1, st, mk(5'd0));
        cpl(1'b1, 4'd4, 32'd5, 1'b0, 4'd0, 32'h0);
        tick();
        check_eq("st_num_retired", num_retired, 2'd1);
        check_eq("st_rd_value", rob_o_1.rd_value, 32'd5);
        check_eq("st_rs1_value", rob_o_1.rs1_value, 32'hAB);
        check_eq("st_opcode", rob_o_1.rd_opcode, OPC_STORE);
        check_eq("st_o2_hold", rob_o_2.rd_value, 32'h33);
        check_eq("st_count", count, 5'd0);

        // Flush beats same-cycle alloc, completion and a pending retire
        alloc(2'd2, mk(5'd6), mk(5'd7));
        alloc(2'd2, mk(5'd8), mk(5'd9));
        alloc(2'd1, mk(5'd10), mk(5'd0));
        check_eq("fl_count_live", count, 5'd5);
        cpl(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66);
        flush     = 1'b1;
        alloc_cnt = 2'd2;
        cpl(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
        flush     = 1'b0;
        alloc_cnt = 2'd0;
        check_eq("fl_count", count, 5'd0);
        check_eq("fl_alloc_idx_1", alloc_idx_1, 4'd0);
        check_eq("fl_num_retired", num_retired, 2'd0);
        tick();
        check_eq("fl_no_retire", num_retired, 2'd0);

        // Fill to full, then a dropped allocation
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check_eq("fill_ready_at_14", alloc_ready, 1'b1);
            alloc(2'd2, mk(5'(2 * k)), mk(5'(2 * k + 1)));
        end
        check_eq("full_count", count, 5'd16);
        check_eq("full_ready", alloc_ready, 1'b0);
        check_eq("full_tail", alloc_idx_1, 4'd0);
        alloc(2'd1, mk(5'd30), mk(5'd0));
        check_eq("drop_count", count, 5'd16);
        check_eq("drop_tail", alloc_idx_1, 4'd0);

        // Retire 14 in order while completing pairs
        for (int j = 0; j < 7; j++) begin
            cpl(1'b1, 4'(2 * j), 32'h100 + 32'(2 * j), 1'b1, 4'(2 * j + 1), 32'h101 + 32'(2 * j));
            if (j > 0) begin
                check_eq("drain_num", num_retired, 2'd2);
                check_eq("drain_o1", rob_o_1.rd_value, 32'h100 + 32'(2 * (j - 1)));
                check_eq("drain_o2", rob_o_2.rd_value, 32'h101 + 32'(2 * (j - 1)));
            end
        end
        tick();
        check_eq("drain_last_o1", rob_o_1.rd_value, 32'h10C);
        check_eq("drain_last_o2", rob_o_2.rd_value, 32'h10D);
        tick();
        check_eq("wrap_idle", num_retired, 2'd0);
        check_eq("wrap_count", count, 5'd2);
        check_eq("wrap_idx_1", alloc_idx_1, 4'd0);
        check_eq("wrap_idx_2", alloc_idx_2, 4'd1);
        check_eq("wrap_ready", alloc_ready, 1'b1);
        alloc(2'd2, mk(5'd20), mk(5'd21));
        check_eq("wrap_tail", alloc_idx_1, 4'd2);
        check_eq("wrap_count4", count, 5'd4);
        cpl(1'b1, 4'd14, 32'h10E, 1'b1, 4'd15, 32'h10F);
        cpl(1'b1, 4'd0, 32'h200, 1'b1, 4'd1, 32'h201);
        check_eq("wrap_ret_a_o1", rob_o_1.rd_value, 32'h10E);
        check_eq("wrap_ret_a_o2", rob_o_2.rd_value, 32'h10F);
        tick();
        check_eq("wrap_ret_b_num", num_retired, 2'd2);
        check_eq("wrap_ret_b_o1", rob_o_1.rd_value, 32'h200);
        check_eq("wrap_ret_b_o2", rob_o_2.rd_value, 32'h201);
        check_eq("wrap_ret_b_rd", rob_o_1.rd_addr, 5'd20);
        check_eq("wrap_count0", count, 5'd0);

        // Asynchronous reset mid-cycle with live entries
        alloc(2'd2, mk(5'd1), mk(5'd2));
        alloc(2'd2, mk(5'd3), mk(5'd4));
        alloc(2'd1, mk(5'd5), mk(5'd0));
        cpl(1'b1, 4'd2, 32'h42, 1'b1, 4'd3, 32'h43);
        tick();
        check_eq("ar_pre_num", num_retired, 2'd2);
        check_eq("ar_pre_count", count, 5'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("ar_count", count, 5'd0);
        check_eq("ar_alloc_idx_1", alloc_idx_1, 4'd0);
        check_eq("ar_num_retired", num_retired, 2'd0);
        check_eq("ar_rob_o_1", rob_o_1, '0);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("ar_post_count", count, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
